// File: rtl/alu_pkg.sv
// Shared constants for the ALU control sequencer: op codes, FSM encoding,
// datapath defaults and instruction field positions.
package alu_pkg;
  localparam int DW_DEF   = 8;
  localparam int NREG_DEF = 4;

  localparam logic [2:0] ALU_ADD     = 3'b000;
  localparam logic [2:0] ALU_SUB     = 3'b001;
  localparam logic [2:0] ALU_AND     = 3'b010;
  localparam logic [2:0] ALU_OR      = 3'b011;
  localparam logic [2:0] ALU_SLT     = 3'b100;
  localparam logic [2:0] ALU_ILLEGAL = 3'b101;
  localparam logic [2:0] ALU_XOR     = 3'b110;
  localparam logic [2:0] ALU_BZ      = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

  // inst = {op[8:6], rd[5:4], rs[3:2], rt[1:0]}
  localparam int INST_W = 9;
  localparam int OP_MSB = 8, OP_LSB = 6;
  localparam int RD_MSB = 5, RD_LSB = 4;
  localparam int RS_MSB = 3, RS_LSB = 2;
  localparam int RT_MSB = 1, RT_LSB = 0;
endpackage

// File: rtl/alu_ctrl_regfile.sv
// Private register file: one write port, two operand read ports and one
// debug read port, all reads combinational, synchronous clear.
module alu_ctrl_regfile
  import alu_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] ra_a_i,
  output logic [DW-1:0] rd_a_o,
  input  logic [AW-1:0] ra_b_i,
  output logic [DW-1:0] rd_b_o,
  input  logic [AW-1:0] ra_dbg_i,
  output logic [DW-1:0] rd_dbg_o
);
  logic [NREG-1:0][DW-1:0] rf_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)   rf_q <= '0;
    else if (we_i) rf_q[waddr_i] <= wdata_i;
  end

  assign rd_a_o   = rf_q[ra_a_i];
  assign rd_b_o   = rf_q[ra_b_i];
  assign rd_dbg_o = rf_q[ra_dbg_i];
endmodule

// File: rtl/alu_ctrl.sv
// Four-state sequencer around an external combinational ALU:
// accept -> read operands -> capture result -> write back.
// Optional zero flag output enabled by defining ALU_CTRL_ZFLAG_EN.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [INST_W-1:0] inst,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_data,
  output logic [2:0]        alu_op,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  input  logic [DW-1:0]     alu_ans,
  output logic              done,
  output logic              illegal,
`ifdef ALU_CTRL_ZFLAG_EN
  output logic              zflag,
`endif
  input  logic [AW-1:0]     rd_sel,
  output logic [DW-1:0]     rd_data
);
  state_t              state_q, state_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [2:0]          op_q, op_d;
  logic [DW-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  logic                rf_we;
  logic [AW-1:0]       rf_waddr;
  logic [DW-1:0]       rf_wdata, rs_data, rt_data;
`ifdef ALU_CTRL_ZFLAG_EN
  logic                zflag_q, zflag_d;
`endif

  logic [2:0]    op_f;
  logic [AW-1:0] rd_f, rs_f, rt_f;
  assign op_f = inst_q[OP_MSB:OP_LSB];
  assign rd_f = inst_q[RD_MSB:RD_LSB];
  assign rs_f = inst_q[RS_MSB:RS_LSB];
  assign rt_f = inst_q[RT_MSB:RT_LSB];

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    inst_ready = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = ld_addr;
    rf_wdata   = ld_data;
`ifdef ALU_CTRL_ZFLAG_EN
    zflag_d    = zflag_q;
`endif
    case (state_q)
      IDLE: begin
        // Preload shares the write port only here, so a same-cycle accept
        // sees the loaded value when operands are read next cycle.
        inst_ready = 1'b1;
        rf_we      = ld_en;
        if (inst_valid) begin
          inst_d  = inst;
          state_d = READ;
        end
      end
      READ: begin
        op_d    = op_f;
        a_d     = rs_data;
        b_d     = rt_data;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu_ans;
        state_d = WB;
      end
      WB: begin
        rf_waddr = rd_f;
        rf_wdata = res_q;
        state_d  = IDLE;
        if (op_f == ALU_ILLEGAL) begin
          illegal = 1'b1;
        end else begin
          done  = 1'b1;
          rf_we = 1'b1;
`ifdef ALU_CTRL_ZFLAG_EN
          zflag_d = (res_q == '0);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inst_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
`ifdef ALU_CTRL_ZFLAG_EN
      zflag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
`ifdef ALU_CTRL_ZFLAG_EN
      zflag_q <= zflag_d;
`endif
    end
  end

  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;
`ifdef ALU_CTRL_ZFLAG_EN
  assign zflag  = zflag_q;
`endif

  alu_ctrl_regfile #(.NREG(NREG), .DW(DW)) u_rf (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .ra_a_i   (rs_f),
    .rd_a_o   (rs_data),
    .ra_b_i   (rt_f),
    .rd_b_o   (rt_data),
    .ra_dbg_i (rd_sel),
    .rd_dbg_o (rd_data)
  );
endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed vector table, hand-written
// back-to-back / reset-abort sequences and a randomized run against a model.
module tb_alu_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0, inst_valid = 1'b0, ld_en = 1'b0;
  logic [8:0] inst = '0;
  logic [1:0] ld_addr = '0, rd_sel = '0;
  logic [7:0] ld_data = '0, alu_ans;
  logic       inst_ready, done, illegal;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, rd_data;
`ifdef ALU_CTRL_ZFLAG_EN
  logic       zflag;
`endif

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  // Behavioural ALU the controller drives.
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return (a < b) ? 8'h01 : 8'h00;
      ALU_XOR: return a ^ b;
      ALU_BZ:  return (a == 8'h00) ? 8'h01 : 8'h00;
      default: return 8'hEE;
    endcase
  endfunction

  always_comb alu_ans = alu_f(alu_op, alu_a, alu_b);

  alu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ans(alu_ans),
    .done(done), .illegal(illegal),
`ifdef ALU_CTRL_ZFLAG_EN
    .zflag(zflag),
`endif
    .rd_sel(rd_sel), .rd_data(rd_data)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [1:0] r, output logic [7:0] v);
    rd_sel = r;
    #1;
    v = rd_data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; inst_valid = 1'b0; ld_en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [1:0] a, input logic [7:0] v);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    tick();
    ld_en = 1'b0;
  endtask

  // Offer one instruction, follow it to its done/illegal cycle, then let WB commit.
  task automatic run_inst(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                          input logic [1:0] rt, output int lat, output logic saw_done,
                          output logic saw_ill, output logic rdy_low);
    int guard = 0;
    inst = {op, rd, rs, rt};
    inst_valid = 1'b1;
    while (!inst_ready && guard < 20) begin tick(); guard++; end
    if (!inst_ready) chk("accept_timeout", 32'(inst_ready), 32'd1);
    tick();
    inst_valid = 1'b0;
    lat = 1; rdy_low = 1'b1;
    while (!(done || illegal) && lat < 10) begin
      if (inst_ready) rdy_low = 1'b0;
      tick(); lat++;
    end
    if (inst_ready) rdy_low = 1'b0;
    saw_done = done; saw_ill = illegal;
    tick();
  endtask

  typedef struct {
    logic [2:0] op; logic [1:0] rd, rs, rt;
    logic [1:0] pa; logic [7:0] pav; logic [1:0] pb; logic [7:0] pbv;
    logic [7:0] exp; logic ill;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int lat; logic sd, si, rl; logic [7:0] v, exp_v; logic zexp;
    logic [7:0] m[4];

    tbl[0] = '{ALU_ADD,     2'd3, 2'd1, 2'd2, 2'd1, 8'h05, 2'd2, 8'h03, 8'h08, 1'b0};
    tbl[1] = '{ALU_SUB,     2'd0, 2'd1, 2'd2, 2'd1, 8'h02, 2'd2, 8'h05, 8'hFD, 1'b0};
    tbl[2] = '{ALU_SLT,     2'd3, 2'd1, 2'd2, 2'd1, 8'h02, 2'd2, 8'h05, 8'h01, 1'b0};
    tbl[3] = '{ALU_BZ,      2'd1, 2'd2, 2'd2, 2'd2, 8'h00, 2'd2, 8'h00, 8'h01, 1'b0};
    tbl[4] = '{ALU_ADD,     2'd2, 2'd0, 2'd1, 2'd0, 8'hFF, 2'd1, 8'h01, 8'h00, 1'b0};
    tbl[5] = '{ALU_ILLEGAL, 2'd0, 2'd1, 2'd2, 2'd0, 8'h5A, 2'd1, 8'h11, 8'h5A, 1'b1};
    tbl[6] = '{ALU_AND,     2'd1, 2'd2, 2'd3, 2'd2, 8'hF0, 2'd3, 8'h3C, 8'h30, 1'b0};
    tbl[7] = '{ALU_XOR,     2'd0, 2'd3, 2'd3, 2'd3, 8'hA5, 2'd3, 8'hA5, 8'h00, 1'b0};
    tbl[8] = '{ALU_OR,      2'd3, 2'd3, 2'd0, 2'd3, 8'h0F, 2'd0, 8'h50, 8'h5F, 1'b0};

    // Reset state
    do_reset();
    chk("rst_ready", 32'(inst_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    for (int r = 0; r < 4; r++) begin
      rd_reg(2'(r), v);
      chk($sformatf("rst_r%0d", r), 32'(v), 32'd0);
    end
`ifdef ALU_CTRL_ZFLAG_EN
    chk("rst_zflag", 32'(zflag), 32'd0);
`endif

    // Directed vector table
    zexp = 1'b0;
    for (int i = 0; i < 9; i++) begin
      preload(tbl[i].pa, tbl[i].pav);
      preload(tbl[i].pb, tbl[i].pbv);
      run_inst(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].rt, lat, sd, si, rl);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_done", i), 32'(sd), 32'(!tbl[i].ill));
      chk($sformatf("v%0d_illegal", i), 32'(si), 32'(tbl[i].ill));
      chk($sformatf("v%0d_ready_low", i), 32'(rl), 32'd1);
      chk($sformatf("v%0d_alu_op_held", i), 32'(alu_op), 32'(tbl[i].op));
      rd_reg(tbl[i].rd, v);
      chk($sformatf("v%0d_rd_value", i), 32'(v), 32'(tbl[i].exp));
      if (!tbl[i].ill) zexp = (tbl[i].exp == 8'h00);
`ifdef ALU_CTRL_ZFLAG_EN
      chk($sformatf("v%0d_zflag", i), 32'(zflag), 32'(zexp));
`endif
    end

    // Back-to-back acceptance with inst_valid held; ld_en in EXEC must be ignored
    begin
      int cyc = 0; int acc[$]; logic rdy_now; int guard = 0;
      do_reset();
      preload(2'd1, 8'h07);
      preload(2'd2, 8'h02);
      inst_valid = 1'b1;
      inst = {ALU_ADD, 2'd0, 2'd1, 2'd2};
      ld_addr = 2'd3; ld_data = 8'hAA;
      while (cyc < 20 && acc.size() < 2) begin
        rdy_now = inst_valid && inst_ready;
        ld_en = (acc.size() == 1) && (cyc == acc[0] + 2);
        tick();
        if (rdy_now) begin
          acc.push_back(cyc);
          if (acc.size() == 1) inst = {ALU_SUB, 2'd1, 2'd1, 2'd2};
          else inst_valid = 1'b0;
        end
        cyc++;
      end
      ld_en = 1'b0; inst_valid = 1'b0;
      chk("b2b_accepts", 32'(acc.size()), 32'd2);
      if (acc.size() == 2) chk("b2b_gap", 32'(acc[1] - acc[0]), 32'd4);
      while (!done && guard < 10) begin tick(); guard++; end
      chk("b2b_second_done", 32'(done), 32'd1);
      tick();
      rd_reg(2'd0, v); chk("b2b_r0", 32'(v), 32'h09);
      rd_reg(2'd1, v); chk("b2b_r1", 32'(v), 32'h05);
      rd_reg(2'd3, v); chk("exec_load_ignored", 32'(v), 32'h00);
    end

    // Reset asserted during EXEC aborts the instruction
    begin
      logic sawd = 1'b0;
      preload(2'd1, 8'h05);
      preload(2'd2, 8'h03);
      preload(2'd3, 8'h77);
      inst = {ALU_ADD, 2'd3, 2'd1, 2'd2};
      inst_valid = 1'b1;
      tick();
      inst_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      repeat (2) begin tick(); if (done) sawd = 1'b1; end
      rst_n = 1'b1;
      chk("abort_ready_after_rst", 32'(inst_ready), 32'd1);
      repeat (4) begin tick(); if (done) sawd = 1'b1; end
      chk("abort_no_done", 32'(sawd), 32'd0);
      chk("abort_ready_idle", 32'(inst_ready), 32'd1);
      rd_reg(2'd3, v); chk("abort_r3", 32'(v), 32'h00);
      rd_reg(2'd1, v); chk("abort_r1", 32'(v), 32'h00);
    end

    // Randomized instructions against the register-file model
    do_reset();
    for (int r = 0; r < 4; r++) m[r] = 8'h00;
    zexp = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [2:0] op; logic [1:0] rd, rs, rt, pr;
      if ($urandom_range(0, 1) == 1) begin
        pr = 2'($urandom_range(0, 3));
        v  = 8'($urandom_range(0, 255));
        preload(pr, v);
        m[pr] = v;
      end
      op = 3'($urandom_range(0, 7));
      rd = 2'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      rt = 2'($urandom_range(0, 3));
      exp_v = alu_f(op, m[rs], m[rt]);
      run_inst(op, rd, rs, rt, lat, sd, si, rl);
      if (op != ALU_ILLEGAL) begin
        m[rd] = exp_v;
        zexp = (exp_v == 8'h00);
      end
      chk($sformatf("rnd%0d_done", n), 32'(sd), 32'(op != ALU_ILLEGAL));
      chk($sformatf("rnd%0d_illegal", n), 32'(si), 32'(op == ALU_ILLEGAL));
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'd3);
      for (int r = 0; r < 4; r++) begin
        rd_reg(2'(r), v);
        chk($sformatf("rnd%0d_r%0d", n, r), 32'(v), 32'(m[r]));
      end
`ifdef ALU_CTRL_ZFLAG_EN
      chk($sformatf("rnd%0d_zflag", n), 32'(zflag), 32'(zexp));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
- Multi-cycle control sequencer that drives the 8-bit combinational ALU: accepts one instruction per handshake, reads two operands from a private 4x8 register file, issues alu_op/a/b, captures ans and writes it back.
- Sits between the instruction source (test harness or fetch logic) and the ALU instance. The parent instantiates both and wires alu_op/alu_a/alu_b/alu_ans.

Parameters:
- NREG, 4, number of architectural registers (index width = clog2(NREG) = 2).
- DW, 8, datapath width; must match the ALU.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- inst_valid  in  1  instruction offered
- inst_ready  out  1  controller can accept an instruction
- inst  in  9  {op[8:6], rd[5:4], rs[3:2], rt[1:0]}
- ld_en  in  1  register preload strobe
- ld_addr  in  2  preload register index
- ld_data  in  8  preload value
- alu_op  out  3  op code to ALU
- alu_a  out  8  operand a (rf[rs])
- alu_b  out  8  operand b (rf[rt])
- alu_ans  in  8  ALU result (combinational)
- done  out  1  one-cycle pulse on writeback
- illegal  out  1  one-cycle pulse when op = 3'b101 completes
- rd_sel  in  2  debug register select
- rd_data  out  8  rf[rd_sel], combinational

Behaviour:
- Clock is clk. Reset is synchronous, active-low rst_n, sampled on the rising clk edge.
- Reset values: state IDLE; inst_ready=1; alu_op=3'b000; alu_a=alu_b=0; done=0; illegal=0; all registers 0.
- FSM IDLE -> READ -> EXEC -> WB -> IDLE. Unconditional except IDLE.
- IDLE: inst_ready=1. On inst_valid&&inst_ready, latch inst and go to READ; otherwise stay. inst_ready=0 in all other states.
- READ: register alu_a<=rf[rs], alu_b<=rf[rt], alu_op<=op.
- EXEC: ALU is stable; result_q<=alu_ans.
- WB: rf[rd]<=result_q and done=1, except op 3'b101: no write, illegal=1, done=0.
- Latency: acceptance edge to done pulse is 3 cycles. Throughput is 1 instruction per 4 cycles.
- Result width is 8 bits; ALU wrap-around is passed through unchanged (0xFF+0x01 -> 0x00).
- SLT and BZ write 0x01/0x00 to rd.
- alu_op/alu_a/alu_b hold their last values outside READ/EXEC; they are not cleared.
- Preload: ld_en is honoured only in IDLE and is ignored in other states.
- Preload and instruction acceptance in the same IDLE cycle: the load commits first, and READ sees the loaded value.
- rs==rt or rd==rs is legal. Reads occur in READ, before WB.
- rst_n low in any state aborts the instruction: no writeback, no done pulse, registers cleared.

Optional Feature:
- Macro: ALU_CTRL_ZFLAG_EN.
- Defined: adds output zflag (1 bit, reset 0), updated in WB to (result_q==0) for legal ops only, held otherwise.
- Undefined: the port and flop are absent.

Decomposition:
- Package alu_pkg holds:
  - ALU_ADD..ALU_BZ op constants and ALU_ILLEGAL=3'b101;
  - state encoding IDLE/READ/EXEC/WB (2 bits);
  - DW and NREG defaults;
  - instruction field-slice constants.
- One sub-module: alu_ctrl_regfile. It has a 4x8 array, 1 write port (arbitrated load/WB), 2 read ports for rs/rt and 1 debug read port, with synchronous reset to 0.

Test Plan:
- Reset, preload r1=0x05 and r2=0x03, ADD r3,r1,r2 -> done 3 cycles after accept; rd_data(r3)=0x08; inst_ready low for 3 cycles.
- Preload r1=0x02, r2=0x05, SUB r0,r1,r2 -> r0=0xFD. Then SLT r3,r1,r2 -> r3=0x01.
- Preload r2=0x00, BZ r1,r2,r2 -> r1=0x01. Then ADD 0xFF+0x01 into r2 -> r2=0x00 (zflag=1 when ALU_CTRL_ZFLAG_EN is defined).
- Illegal op 3'b101 with rd=r0 holding 0x5A -> illegal pulses, done stays 0, r0 stays 0x5A.
- Hold inst_valid high with two back-to-back instructions -> second accepted exactly 4 cycles after the first. ld_en asserted during EXEC is ignored.
- Assert rst_n=0 during EXEC of ADD r3 -> no done pulse, r3=0x00, state IDLE, inst_ready=1 the cycle after rst_n rises.
